// File: rtl/mbinit_repairclk_tx.sv
// rtl/mbinit_repairclk_tx.sv - MBINIT.REPAIRCLK initiator sideband handshake FSM
module mbinit_repairclk_tx #(
    parameter int SB_MSG_Width   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 11
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_mbinit_repairclk_en,
    input  logic                    i_sb_busy,
    input  logic                    i_falling_edge_busy,
    input  logic [SB_MSG_Width-1:0] i_decoded_sb_msg,
    input  logic                    i_sb_valid,
    input  logic [2:0]              i_msg_info,
    input  logic                    i_pattern_done,
    output logic [SB_MSG_Width-1:0] o_encoded_sb_msg,
    output logic                    o_msg_valid,
    output logic                    o_pattern_en,
    output logic [2:0]              o_results,
    output logic                    o_tx_end,
    output logic                    o_repair_fail,
    output logic                    o_timeout
);

    localparam logic [SB_MSG_Width-1:0] MSG_INIT_REQ    = SB_MSG_Width'(1);
    localparam logic [SB_MSG_Width-1:0] MSG_INIT_RESP   = SB_MSG_Width'(2);
    localparam logic [SB_MSG_Width-1:0] MSG_RESULT_REQ  = SB_MSG_Width'(3);
    localparam logic [SB_MSG_Width-1:0] MSG_RESULT_RESP = SB_MSG_Width'(4);
    localparam logic [SB_MSG_Width-1:0] MSG_DONE_REQ    = SB_MSG_Width'(5);
    localparam logic [SB_MSG_Width-1:0] MSG_DONE_RESP   = SB_MSG_Width'(6);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        CHECK_BUSY_INIT,
        SEND_INIT_REQ,
        WAIT_INIT_RESP,
        SEND_PATTERN,
        CHECK_BUSY_RES,
        SEND_RES_REQ,
        WAIT_RES_RESP,
        CHECK_BUSY_DONE,
        SEND_DONE_REQ,
        WAIT_DONE_RESP,
        TX_END,
        ERROR
    } state_t;

    state_t                  cs, ns;
    logic [TIMEOUT_W-1:0]    cnt, cnt_n;
    logic [SB_MSG_Width-1:0] msg_n;
    logic                    valid_n, pat_n, end_n, rfail_n, tout_n;
    logic [2:0]              res_n;
    logic                    cnt_done;

    assign cnt_done = (cnt == CNT_LAST);

    // State, counter and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs               <= IDLE;
            cnt              <= '0;
            o_encoded_sb_msg <= '0;
            o_msg_valid      <= 1'b0;
            o_pattern_en     <= 1'b0;
            o_results        <= 3'b000;
            o_tx_end         <= 1'b0;
            o_repair_fail    <= 1'b0;
            o_timeout        <= 1'b0;
        end else begin
            cs               <= ns;
            cnt              <= cnt_n;
            o_encoded_sb_msg <= msg_n;
            o_msg_valid      <= valid_n;
            o_pattern_en     <= pat_n;
            o_results        <= res_n;
            o_tx_end         <= end_n;
            o_repair_fail    <= rfail_n;
            o_timeout        <= tout_n;
        end
    end

    // Next state, response timeout and output decode from the next state
    always_comb begin
        ns      = cs;
        cnt_n   = '0;
        msg_n   = '0;
        valid_n = 1'b0;
        pat_n   = 1'b0;
        res_n   = o_results;
        end_n   = 1'b0;
        rfail_n = 1'b0;
        tout_n  = 1'b0;

        if (!i_mbinit_repairclk_en) begin
            ns    = IDLE;
            res_n = 3'b000;
        end else begin
            case (cs)
                IDLE:            ns = CHECK_BUSY_INIT;
                CHECK_BUSY_INIT: if (!i_sb_busy) ns = SEND_INIT_REQ;
                SEND_INIT_REQ:   if (i_falling_edge_busy) ns = WAIT_INIT_RESP;
                WAIT_INIT_RESP: begin
                    if (i_sb_valid && i_decoded_sb_msg == MSG_INIT_RESP) begin
                        ns = SEND_PATTERN;
                    end else if (cnt_done) begin
                        ns     = ERROR;
                        tout_n = 1'b1;
                    end
                end
                SEND_PATTERN:    if (i_pattern_done) ns = CHECK_BUSY_RES;
                CHECK_BUSY_RES:  if (!i_sb_busy) ns = SEND_RES_REQ;
                SEND_RES_REQ:    if (i_falling_edge_busy) ns = WAIT_RES_RESP;
                WAIT_RES_RESP: begin
                    if (i_sb_valid && i_decoded_sb_msg == MSG_RESULT_RESP) begin
                        res_n = i_msg_info;
                        if (i_msg_info == 3'b111) begin
                            ns = CHECK_BUSY_DONE;
                        end else begin
                            ns      = ERROR;
                            rfail_n = 1'b1;
                        end
                    end else if (cnt_done) begin
                        ns     = ERROR;
                        tout_n = 1'b1;
                    end
                end
                CHECK_BUSY_DONE: if (!i_sb_busy) ns = SEND_DONE_REQ;
                SEND_DONE_REQ:   if (i_falling_edge_busy) ns = WAIT_DONE_RESP;
                WAIT_DONE_RESP: begin
                    if (i_sb_valid && i_decoded_sb_msg == MSG_DONE_RESP) begin
                        ns = TX_END;
                    end else if (cnt_done) begin
                        ns     = ERROR;
                        tout_n = 1'b1;
                    end
                end
                TX_END:          ns = TX_END;
                ERROR: begin
                    // Cause flags were set on entry and stay until enable drops
                    ns      = ERROR;
                    rfail_n = o_repair_fail;
                    tout_n  = o_timeout;
                end
                default:         ns = IDLE;
            endcase

            // Counter runs only while parked in a WAIT_* state
            if (ns == cs && (cs == WAIT_INIT_RESP || cs == WAIT_RES_RESP ||
                             cs == WAIT_DONE_RESP)) begin
                cnt_n = cnt + 1'b1;
            end

            case (ns)
                SEND_INIT_REQ: begin
                    valid_n = 1'b1;
                    msg_n   = MSG_INIT_REQ;
                end
                SEND_RES_REQ: begin
                    valid_n = 1'b1;
                    msg_n   = MSG_RESULT_REQ;
                end
                SEND_DONE_REQ: begin
                    valid_n = 1'b1;
                    msg_n   = MSG_DONE_REQ;
                end
                SEND_PATTERN: pat_n = 1'b1;
                TX_END:       end_n = 1'b1;
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_mbinit_repairclk_tx.sv
// tb/tb_mbinit_repairclk_tx.sv - directed self-checking bench for mbinit_repairclk_tx
module tb_mbinit_repairclk_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sb_busy = 1'b0;
    logic       feb = 1'b0;
    logic [3:0] dec_msg = 4'd0;
    logic       sb_valid = 1'b0;
    logic [2:0] info = 3'd0;
    logic       pat_done = 1'b0;
    logic [3:0] enc_msg;
    logic       msg_valid, pattern_en, tx_end, repair_fail, timeout;
    logic [2:0] results;

    int total = 0;
    int bad = 0;

    mbinit_repairclk_tx #(
        .SB_MSG_Width  (4),
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_W     (5)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_mbinit_repairclk_en(en),
        .i_sb_busy            (sb_busy),
        .i_falling_edge_busy  (feb),
        .i_decoded_sb_msg     (dec_msg),
        .i_sb_valid           (sb_valid),
        .i_msg_info           (info),
        .i_pattern_done       (pat_done),
        .o_encoded_sb_msg     (enc_msg),
        .o_msg_valid          (msg_valid),
        .o_pattern_en         (pattern_en),
        .o_results            (results),
        .o_tx_end             (tx_end),
        .o_repair_fail        (repair_fail),
        .o_timeout            (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_feb();
        feb = 1'b1;
        step(1);
        feb = 1'b0;
    endtask

    task automatic send_msg(input logic [3:0] code, input logic [2:0] inf);
        sb_valid = 1'b1;
        dec_msg  = code;
        info     = inf;
        step(1);
        sb_valid = 1'b0;
        dec_msg  = 4'd0;
        info     = 3'd0;
    endtask

    task automatic pulse_pat();
        pat_done = 1'b1;
        step(1);
        pat_done = 1'b0;
    endtask

    // Restart from IDLE and advance to WAIT_INIT_RESP (first cycle there)
    task automatic to_wait_init();
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(2);
        pulse_feb();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, msg_valid, 0);
        check({tag, "_pat"}, pattern_en, 0);
        check({tag, "_res"}, results, 0);
        check({tag, "_end"}, tx_end, 0);
        check({tag, "_fail"}, repair_fail, 0);
        check({tag, "_tout"}, timeout, 0);
        check({tag, "_code"}, enc_msg, 0);
    endtask

    initial begin
        step(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        step(1);

        // Nominal flow
        en = 1'b1;
        step(1);
        check("nom_lat1_valid", msg_valid, 0);
        step(1);
        check("nom_init_valid", msg_valid, 1);
        check("nom_init_code", enc_msg, 4'b0001);
        step(2);
        check("nom_init_hold", msg_valid, 1);
        pulse_feb();
        check("nom_wait_valid", msg_valid, 0);
        send_msg(4'b0010, 3'd0);
        check("nom_pat_on", pattern_en, 1);
        step(3);
        check("nom_pat_hold", pattern_en, 1);
        pulse_pat();
        check("nom_pat_off", pattern_en, 0);
        step(1);
        check("nom_res_valid", msg_valid, 1);
        check("nom_res_code", enc_msg, 4'b0011);
        pulse_feb();
        send_msg(4'b0100, 3'b111);
        check("nom_results", results, 3'b111);
        step(1);
        check("nom_done_valid", msg_valid, 1);
        check("nom_done_code", enc_msg, 4'b0101);
        pulse_feb();
        send_msg(4'b0110, 3'd0);
        check("nom_tx_end", tx_end, 1);
        step(5);
        check("nom_tx_end_hold", tx_end, 1);
        check("nom_results_hold", results, 3'b111);
        check("nom_fail", repair_fail, 0);

        // Noise in WAIT_RES_RESP, then repair fail
        to_wait_init();
        send_msg(4'b0010, 3'd0);
        pulse_pat();
        step(1);
        pulse_feb();
        send_msg(4'b0010, 3'b111);
        check("noise1_valid", msg_valid, 0);
        check("noise1_pat", pattern_en, 0);
        check("noise1_res", results, 0);
        send_msg(4'b0110, 3'b111);
        check("noise2_valid", msg_valid, 0);
        check("noise2_end", tx_end, 0);
        check("noise2_res", results, 0);
        send_msg(4'b0100, 3'b101);
        check("fail_results", results, 3'b101);
        check("fail_flag", repair_fail, 1);
        step(5);
        check("fail_flag_hold", repair_fail, 1);
        check("fail_no_done_req", msg_valid, 0);
        check("fail_tx_end", tx_end, 0);
        check("fail_tout", timeout, 0);

        // Busy stall entering CHECK_BUSY_RES
        to_wait_init();
        send_msg(4'b0010, 3'd0);
        sb_busy = 1'b1;
        pulse_pat();
        for (int i = 0; i < 20; i++) begin
            check("stall_valid", msg_valid, 0);
            step(1);
        end
        sb_busy = 1'b0;
        step(1);
        check("stall_res_valid", msg_valid, 1);
        check("stall_res_code", enc_msg, 4'b0011);

        // Timeout: no init_resp
        to_wait_init();
        step(15);
        check("tout_before", timeout, 0);
        step(1);
        check("tout_set", timeout, 1);
        step(5);
        check("tout_hold", timeout, 1);
        check("tout_fail", repair_fail, 0);

        // init_resp on the 16th waiting cycle wins over timeout
        to_wait_init();
        step(15);
        send_msg(4'b0010, 3'd0);
        check("edge_tout", timeout, 0);
        check("edge_pat", pattern_en, 1);

        // Enable dropped mid-pattern, then restart
        step(2);
        en = 1'b0;
        step(1);
        check_all_zero("drop");
        en = 1'b1;
        step(2);
        check("restart_valid", msg_valid, 1);
        check("restart_code", enc_msg, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbinit_repairclk_tx.md
Name: mbinit_repairclk_tx

Overview:
- Initiator side of the MBINIT.REPAIRCLK sideband handshake; pairs with the REPAIRCLK receiver/responder on the partner die.
- Sequence: send init_req, wait for init_resp, run the repair-clock pattern, send result_req, capture the logged results from result_resp, send done_req, wait for done_resp.
- Sits between the MBINIT sequencer (enable, end, fail) and the sideband encoder/decoder, and drives the clock-pattern generator.

Parameters:
- SB_MSG_Width, 4, width of the encoded and decoded sideband message codes.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in any WAIT_* state before aborting.
- TIMEOUT_W, 11, width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_mbinit_repairclk_en  in  1  substate enable from the MBINIT sequencer; low forces IDLE
- i_sb_busy  in  1  sideband transmitter busy
- i_falling_edge_busy  in  1  one-cycle pulse when i_sb_busy falls; marks message sent
- i_decoded_sb_msg  in  SB_MSG_Width  decoded received message code
- i_sb_valid  in  1  i_decoded_sb_msg is valid this cycle
- i_msg_info  in  3  result bits carried in result_resp: [0] RCKP, [1] RCKN, [2] RTRK; 1 = pass
- i_pattern_done  in  1  pulse from the pattern generator when the pattern burst is finished
- o_encoded_sb_msg  out  SB_MSG_Width  message code to the sideband encoder
- o_msg_valid  out  1  request the sideband to send o_encoded_sb_msg
- o_pattern_en  out  1  enable the repair-clock pattern generator
- o_results  out  3  latched partner results
- o_tx_end  out  1  substate completed successfully
- o_repair_fail  out  1  results were not all-pass
- o_timeout  out  1  no response arrived within TIMEOUT_CYCLES

Behaviour:
- Message codes: init_req 0001, init_resp 0010, result_req 0011, result_resp 0100, done_req 0101, done_resp 0110.
- Reset: state IDLE, timeout counter 0, all outputs 0.
- State register updates on posedge i_clk.
- Outputs are registered and decoded from the next state NS. Every output except o_results defaults to 0 each cycle.
- Enable low: NS = IDLE with top priority. All outputs, including o_results, clear on the next edge. The counter clears.
- Transitions:
  - IDLE -> CHECK_BUSY_INIT when enable is high.
  - CHECK_BUSY_INIT -> SEND_INIT_REQ when i_sb_busy is low.
  - SEND_INIT_REQ -> WAIT_INIT_RESP on i_falling_edge_busy.
  - WAIT_INIT_RESP -> SEND_PATTERN on i_sb_valid with code init_resp.
  - SEND_PATTERN -> CHECK_BUSY_RES on i_pattern_done.
  - CHECK_BUSY_RES -> SEND_RES_REQ when i_sb_busy is low.
  - SEND_RES_REQ -> WAIT_RES_RESP on i_falling_edge_busy.
  - WAIT_RES_RESP on i_sb_valid with code result_resp: -> CHECK_BUSY_DONE if i_msg_info == 3'b111, else -> ERROR.
  - CHECK_BUSY_DONE -> SEND_DONE_REQ when i_sb_busy is low.
  - SEND_DONE_REQ -> WAIT_DONE_RESP on i_falling_edge_busy.
  - WAIT_DONE_RESP -> TX_END on i_sb_valid with code done_resp.
  - TX_END and ERROR hold until enable goes low.
- Output decode:
  - SEND_INIT_REQ: o_msg_valid = 1, o_encoded_sb_msg = init_req.
  - SEND_RES_REQ: o_msg_valid = 1, o_encoded_sb_msg = result_req.
  - SEND_DONE_REQ: o_msg_valid = 1, o_encoded_sb_msg = done_req.
  - o_msg_valid stays high for every cycle spent in a SEND_* state.
  - SEND_PATTERN: o_pattern_en = 1.
  - TX_END: o_tx_end = 1.
  - ERROR: o_repair_fail or o_timeout per cause. Both are sticky until enable goes low.
- o_results: loaded with i_msg_info in the cycle the result_resp is accepted; held afterwards. Cleared only by reset or enable low.
- Unexpected or out-of-order decoded messages (valid but wrong code) are ignored. The state is unchanged.
- i_falling_edge_busy outside a SEND_* state is ignored.
- Timeout:
  - The counter increments every cycle in WAIT_INIT_RESP, WAIT_RES_RESP or WAIT_DONE_RESP. It clears on any state change.
  - When the counter reaches TIMEOUT_CYCLES-1 without the expected message, NS = ERROR with o_timeout = 1.
  - If the expected message arrives in that same cycle, the message wins.
- Latency: o_msg_valid rises 2 cycles after enable when the sideband is idle (IDLE -> CHECK_BUSY_INIT -> SEND_INIT_REQ, output registered from NS).

Test Plan:
- Nominal flow: enable high, sideband idle, partner replies init_resp, pattern done, result_resp with info=111, done_resp.
  - Required: o_msg_valid with codes 0001, 0011, 0101 in order.
  - o_pattern_en high between init_resp and i_pattern_done.
  - o_results = 111; o_tx_end = 1 and held.
- Repair fail: result_resp with info=101.
  - Required: o_results = 101, o_repair_fail = 1, no done_req is sent, o_tx_end = 0.
- Busy stall: i_sb_busy high for 20 cycles entering CHECK_BUSY_RES.
  - Required: o_msg_valid = 0 throughout; result_req is issued 1 cycle after busy falls.
- Timeout with TIMEOUT_CYCLES=16: no init_resp is sent.
  - Required: o_timeout = 1 after 16 cycles in WAIT_INIT_RESP; stays 1.
  - Second case: init_resp arrives on the 16th cycle -> no timeout, o_pattern_en = 1.
- Enable dropped mid-pattern.
  - Required: all outputs 0 on the next edge. Re-enable restarts from init_req.
- Noise: while in WAIT_RES_RESP, inject valid init_resp and done_resp codes.
  - Required: state and outputs unchanged. A later result_resp is still accepted.
